uart_rx_buffer: RTL and testbench



---
 rtl/uart_rx_buffer_pkg.sv | 22 ++
 rtl/uart_rx_mem.sv | 28 ++
 rtl/uart_rx_buffer.sv | 99 +++++++++
 tb/tb_uart_rx_buffer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buffer_pkg.sv
// Shared defaults and helpers for the UART receive buffer.
package uart_rx_buffer_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH_LOG2 = 4;
    localparam int DEF_DEPTH      = 1 << DEF_DEPTH_LOG2;
    localparam int DEF_RTS_HI     = 12;
    localparam int DEF_RTS_LO     = 8;

    // Hysteresis: drop at/above hi, raise at/below lo, hold in between.
    function automatic logic rts_update(input int lvl, input int hi,
                                        input int lo, input logic cur);
        logic nxt;
        nxt = cur;
        if (lvl >= hi)
            nxt = 1'b0;
        else if (lvl <= lo)
            nxt = 1'b1;
        return nxt;
    endfunction

endpackage

// File: rtl/uart_rx_mem.sv
// DEPTH x DATA_W register array: one synchronous write, one async read.
module uart_rx_mem
    import uart_rx_buffer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Storage is never cleared; stale bytes are hidden by the level gate.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive elastic FIFO with first-word fall-through, rts hysteresis and
// sticky overrun.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int RTS_HI     = DEF_RTS_HI,
    parameter int RTS_LO     = DEF_RTS_LO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_soft,
    input  logic                  rx_en,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  rts,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH[DEPTH_LOG2:0];

    logic                  reset;
    logic                  push;
    logic                  pop_eff;
    logic                  full;
    logic                  do_push;
    logic                  overflow;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  rts_q, rts_next;
    logic [DATA_W-1:0]     rd_data;

    assign reset    = rst | rst_soft;
    assign push     = in_valid & rx_en;
    assign pop_eff  = pop & (level != '0);
    assign full     = (level == LVL_FULL);
    // A full FIFO still takes a byte when the same cycle frees a slot.
    assign do_push  = push & (~full | pop_eff);
    assign overflow = push & full & ~pop_eff;

    // Next level and rts from this cycle's push/pop decision.
    always_comb begin
        level_next = level;
        case ({do_push, pop_eff})
            2'b10:   level_next = level + LVL_ONE;
            2'b01:   level_next = level - LVL_ONE;
            default: level_next = level;
        endcase
        rts_next = rts_update(int'(level_next), RTS_HI, RTS_LO, rts_q);
    end

    // Pointer, level, rts and overrun state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rts_q   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_eff)
                rd_ptr <= rd_ptr + PTR_ONE;
            level <= level_next;
            rts_q <= rts_next;
            if (overflow)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    uart_rx_mem #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (do_push & ~reset),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign out_ready = (level != '0);
    assign out_data  = out_ready ? rd_data : '0;
    assign rts       = rts_q & rx_en;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer.
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_soft = 1'b0;
    logic       rx_en = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       pop = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] level;
    logic       rts;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    uart_rx_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .rst_soft    (rst_soft),
        .rx_en       (rx_en),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .pop         (pop),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .level       (level),
        .rts         (rts),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_b(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    // Check the head byte, then pop it.
    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, out_data}, {24'd0, exp});
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        // reset / empty
        step(); step();
        rst = 1'b0;
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_ready", {31'd0, out_ready}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_rts", {31'd0, rts}, 32'd1);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        pop = 1'b1; step(); pop = 1'b0;
        chk("empty_pop_level", {27'd0, level}, 32'd0);
        chk("empty_pop_data", {24'd0, out_data}, 32'd0);

        // ordering with wrap
        for (int i = 0; i < 16; i++) push_b(8'(8'h41 + i));
        chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_ready", {31'd0, out_ready}, 32'd1);
        for (int i = 0; i < 16; i++) pop_chk("order_a", 8'(8'h41 + i));
        chk("drain_level", {27'd0, level}, 32'd0);
        for (int i = 0; i < 4; i++) push_b(8'(8'h51 + i));
        for (int i = 0; i < 4; i++) pop_chk("order_wrap", 8'(8'h51 + i));
        chk("wrap_level", {27'd0, level}, 32'd0);

        // hysteresis
        for (int i = 0; i < 11; i++) push_b(8'(i));
        chk("hys_rts11", {31'd0, rts}, 32'd1);
        push_b(8'd11);
        chk("hys_rts12", {31'd0, rts}, 32'd0);
        for (int i = 0; i < 3; i++) pop_chk("hys_pop", 8'(i));
        chk("hys_level9", {27'd0, level}, 32'd9);
        chk("hys_rts9", {31'd0, rts}, 32'd0);
        pop_chk("hys_pop", 8'd3);
        chk("hys_level8", {27'd0, level}, 32'd8);
        chk("hys_rts8", {31'd0, rts}, 32'd1);
        for (int i = 4; i < 12; i++) pop_chk("hys_drain", 8'(i));
        chk("hys_empty", {27'd0, level}, 32'd0);

        // overrun
        for (int i = 0; i < 16; i++) push_b(8'(8'h60 + i));
        chk("ovr_rts_full", {31'd0, rts}, 32'd0);
        push_b(8'hEE);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_level", {27'd0, level}, 32'd16);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        overrun_clr = 1'b1; push_b(8'hEF); overrun_clr = 1'b0;
        chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("ovr_clr2", {31'd0, overrun}, 32'd0);

        // simultaneous push+pop when full
        chk("sim_head", {24'd0, out_data}, 32'h60);
        in_valid = 1'b1; in_data = 8'h77; pop = 1'b1;
        step();
        in_valid = 1'b0; pop = 1'b0;
        chk("sim_full_level", {27'd0, level}, 32'd16);
        chk("sim_full_ovr", {31'd0, overrun}, 32'd0);
        for (int i = 1; i < 16; i++) pop_chk("sim_order", 8'(8'h60 + i));
        pop_chk("sim_last", 8'h77);
        chk("sim_empty", {27'd0, level}, 32'd0);
        chk("sim_rts_back", {31'd0, rts}, 32'd1);

        // simultaneous push+pop when empty
        in_valid = 1'b1; in_data = 8'h33; pop = 1'b1;
        step();
        in_valid = 1'b0; pop = 1'b0;
        chk("sim_empty_level", {27'd0, level}, 32'd1);
        chk("sim_empty_data", {24'd0, out_data}, 32'h33);
        pop_chk("sim_empty_pop", 8'h33);

        // soft reset
        for (int i = 0; i < 5; i++) push_b(8'(8'hA0 + i));
        chk("soft_pre", {27'd0, level}, 32'd5);
        rst_soft = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        step();
        rst_soft = 1'b0; in_valid = 1'b0;
        chk("soft_level", {27'd0, level}, 32'd0);
        chk("soft_ready", {31'd0, out_ready}, 32'd0);
        chk("soft_rts", {31'd0, rts}, 32'd1);
        chk("soft_data", {24'd0, out_data}, 32'd0);

        // rx enable
        push_b(8'hC1);
        push_b(8'hC2);
        rx_en = 1'b0;
        #1;
        chk("dis_rts", {31'd0, rts}, 32'd0);
        push_b(8'h99);
        push_b(8'h9A);
        chk("dis_level", {27'd0, level}, 32'd2);
        pop_chk("dis_drain", 8'hC1);
        chk("dis_drain_level", {27'd0, level}, 32'd1);
        chk("dis_head", {24'd0, out_data}, 32'hC2);
        rx_en = 1'b1;
        #1;
        chk("en_rts", {31'd0, rts}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
